// File: rtl/vliw_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : vliw_fwd_scoreboard
//  Purpose  : Pending-write tracker for the VLIW pipeline. It produces
//             per-operand forwarding selects, a load-use stall and a
//             saturating stall counter.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module vliw_fwd_scoreboard #(
    parameter int SLOTS      = 2,
    parameter int AW         = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 3,
    parameter int SW         = $clog2(DEPTH + 1),
    parameter int LW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [SLOTS*AW-1:0]     src_a,
    input  logic [SLOTS*AW-1:0]     src_b,
    input  logic [SLOTS*AW-1:0]     dst,
    input  logic [SLOTS-1:0]        dst_we,
    input  logic [SLOTS-1:0]        dst_load,
    input  logic                    flush,
    output logic [2*SLOTS-1:0]      fwd_hit,
    output logic [2*SLOTS*SW-1:0]   fwd_stage,
    output logic [2*SLOTS*LW-1:0]   fwd_slot,
    output logic                    stall,
    output logic [15:0]             stall_count
);

    localparam logic [SW-1:0] c_load_stage = SW'(LOAD_STAGE);
    localparam logic [15:0]   c_count_max  = 16'hFFFF;

    // Index 0 of each array is stage 1 (EX)
    logic [DEPTH-1:0][SLOTS-1:0]    r_valid;
    logic [DEPTH-1:0][SLOTS*AW-1:0] r_dst;
    logic [DEPTH-1:0][SLOTS-1:0]    r_load;
    logic [15:0]                    r_stall_count;

    logic [2*SLOTS-1:0] w_hazard;
    logic               w_stall;
    logic               w_accept;

    generate
        for (genvar gs = 0; gs < SLOTS; gs++) begin : g_slot
            for (genvar gp = 0; gp < 2; gp++) begin : g_opnd
                localparam int c_op = 2 * gs + gp;

                logic [AW-1:0] w_src;
                logic          w_found;
                logic          w_load;
                logic [SW-1:0] w_stage;
                logic [LW-1:0] w_slot;
                logic          w_haz;
                logic          w_hit;

                assign w_src = (gp == 0) ? src_a[gs*AW +: AW] : src_b[gs*AW +: AW];

                // Oldest-to-youngest scan: the last hit written is the lowest
                // stage and, within it, the highest slot.
                always_comb begin
                    w_found = 1'b0;
                    w_load  = 1'b0;
                    w_stage = '0;
                    w_slot  = '0;
                    for (int k = DEPTH - 1; k >= 0; k--) begin
                        for (int s = 0; s < SLOTS; s++) begin
                            if (r_valid[k][s] && (r_dst[k][s*AW +: AW] == w_src)) begin
                                w_found = 1'b1;
                                w_load  = r_load[k][s];
                                w_stage = SW'(k + 1);
                                w_slot  = LW'(s);
                            end
                        end
                    end
                end

                assign w_haz          = w_found && w_load && (w_stage < c_load_stage);
                assign w_hit          = w_found && !w_haz;
                assign w_hazard[c_op] = w_haz;

                assign fwd_hit[c_op]             = w_hit;
                assign fwd_stage[c_op*SW +: SW]  = w_hit ? w_stage : '0;
                assign fwd_slot[c_op*LW +: LW]   = w_hit ? w_slot  : '0;
            end
        end
    endgenerate

    // A flushed bundle never stalls; it is simply replaced by a bubble
    assign w_stall  = issue_valid && !flush && (|w_hazard);
    assign w_accept = issue_valid && !w_stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= '0;
            r_stall_count <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
            end
            r_valid[0] <= w_accept ? dst_we : '0;
            if (w_stall && (r_stall_count != c_count_max)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    // Payload only matters where the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
            r_dst[k]  <= r_dst[k-1];
            r_load[k] <= r_load[k-1];
        end
        r_dst[0]  <= dst;
        r_load[0] <= dst_load;
    end

    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_vliw_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vliw_fwd_scoreboard
//  Purpose  : Directed scoreboard bench for vliw_fwd_scoreboard (2 slots,
//             4-bit addresses, 3 stages, loads forwardable from stage 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vliw_fwd_scoreboard;

    localparam int SLOTS = 2;
    localparam int AW    = 4;
    localparam int SW    = 2;
    localparam int LW    = 1;

    logic                  clk;
    logic                  reset;
    logic                  issue_valid;
    logic [SLOTS*AW-1:0]   src_a;
    logic [SLOTS*AW-1:0]   src_b;
    logic [SLOTS*AW-1:0]   dst;
    logic [SLOTS-1:0]      dst_we;
    logic [SLOTS-1:0]      dst_load;
    logic                  flush;
    logic [2*SLOTS-1:0]    fwd_hit;
    logic [2*SLOTS*SW-1:0] fwd_stage;
    logic [2*SLOTS*LW-1:0] fwd_slot;
    logic                  stall;
    logic [15:0]           stall_count;

    vliw_fwd_scoreboard #(
        .SLOTS      (SLOTS),
        .AW         (AW),
        .DEPTH      (3),
        .LOAD_STAGE (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .src_a       (src_a),
        .src_b       (src_b),
        .dst         (dst),
        .dst_we      (dst_we),
        .dst_load    (dst_load),
        .flush       (flush),
        .fwd_hit     (fwd_hit),
        .fwd_stage   (fwd_stage),
        .fwd_slot    (fwd_slot),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: {hit, stage[1:0], slot} of operand op; kind 1: stall; kind 2: stall_count
    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        int          op;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string name, input int kind, input int op, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.kind = kind;
        e.op   = op;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_fwd(input string name, input int op, input logic hit,
                           input logic [1:0] stg, input logic sl);
        push(name, 0, op, {12'd0, hit, stg, sl});
    endtask

    task automatic exp_stall(input string name, input logic v);
        push(name, 1, 0, {15'd0, v});
    endtask

    task automatic exp_cnt(input string name, input logic [15:0] v);
        push(name, 2, 0, v);
    endtask

    // Monitor: compares every expectation due in this cycle on the falling edge
    exp_t        m_e;
    logic [15:0] m_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            case (m_e.kind)
                0:       m_act = {12'd0, fwd_hit[m_e.op], fwd_stage[m_e.op*SW +: SW], fwd_slot[m_e.op]};
                1:       m_act = {15'd0, stall};
                default: m_act = stall_count;
            endcase
            total++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                bad++;
                $display("FAIL %s (cycle %0d): got %h, want %h", m_e.name, cyc, m_act, m_e.val);
            end
        end
    end

    task automatic drv(input logic v,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic [1:0] we, input logic [1:0] ld, input logic fl);
        issue_valid = v;
        src_a       = {a1, a0};
        src_b       = {b1, b0};
        dst         = {d1, d0};
        dst_we      = we;
        dst_load    = ld;
        flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;

        // Reset state
        idle();
        for (int o = 0; o < 4; o++) exp_fwd("reset_fwd", o, 1'b0, 2'd0, 1'b0);
        exp_stall("reset_stall", 1'b0);
        exp_cnt("reset_cnt", 16'd0);
        step();

        // ALU chain: slot0 writes r5, then walk it through EX/MEM/WB and out
        drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 2'b01, 2'b00, 1'b0);
        exp_stall("alu_issue_stall", 1'b0);
        step();
        drv(1'b1, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_fwd("alu_ex", 2, 1'b1, 2'd1, 1'b0);
        exp_fwd("alu_nomatch", 0, 1'b0, 2'd0, 1'b0);
        exp_stall("alu_stall", 1'b0);
        step();
        drv(1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_fwd("alu_mem", 0, 1'b1, 2'd2, 1'b0);
        step();
        exp_fwd("alu_wb", 0, 1'b1, 2'd3, 1'b0);
        step();
        exp_fwd("alu_retired", 0, 1'b0, 2'd0, 1'b0);
        step();

        // Priority: highest slot within a stage, youngest stage overall
        drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd3, 2'b11, 2'b00, 1'b0);
        step();
        drv(1'b1, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_fwd("pri_slot", 1, 1'b1, 2'd1, 1'b1);
        step();
        drv(1'b1, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 4'd0, 2'b01, 2'b00, 1'b0);
        exp_fwd("pri_intra", 1, 1'b1, 2'd2, 1'b1);
        step();
        drv(1'b1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_fwd("pri_young", 0, 1'b1, 2'd1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            step();
        end

        // Load-use: slot1 loads r7, dependent bundle held two cycles
        drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 2'b10, 2'b10, 1'b0);
        exp_stall("ld_issue", 1'b0);
        step();
        drv(1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_stall("ld_stall1", 1'b1);
        exp_fwd("ld_hold1", 0, 1'b0, 2'd0, 1'b0);
        step();
        exp_stall("ld_stall2", 1'b1);
        exp_fwd("ld_hold2", 0, 1'b0, 2'd0, 1'b0);
        step();
        exp_stall("ld_release", 1'b0);
        exp_fwd("ld_fwd", 0, 1'b1, 2'd3, 1'b1);
        exp_cnt("ld_cnt", 16'd2);
        step();

        // Flush during the first stall cycle
        drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 2'b10, 2'b10, 1'b0);
        step();
        drv(1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 2'b01, 2'b00, 1'b1);
        exp_stall("fl_nostall", 1'b0);
        exp_fwd("fl_hazard_nohit", 0, 1'b0, 2'd0, 1'b0);
        step();
        drv(1'b0, 4'd7, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        exp_fwd("fl_bubble", 1, 1'b0, 2'd0, 1'b0);
        exp_stall("fl_idle", 1'b0);
        step();
        exp_fwd("fl_load_wb", 0, 1'b1, 2'd3, 1'b1);
        exp_cnt("fl_cnt", 16'd2);
        step();

        // Reset while entries are pending and stall is asserted
        drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 2'b11, 2'b10, 1'b0);
        step();
        drv(1'b1, 4'd7, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0);
        reset = 1'b1;
        exp_stall("rst_pre_stall", 1'b1);
        exp_fwd("rst_pre_fwd", 2, 1'b1, 2'd1, 1'b0);
        exp_cnt("rst_pre_cnt", 16'd2);
        step();
        reset = 1'b0;
        exp_stall("rst_stall", 1'b0);
        exp_fwd("rst_op0", 0, 1'b0, 2'd0, 1'b0);
        exp_fwd("rst_op2", 2, 1'b0, 2'd0, 1'b0);
        exp_cnt("rst_cnt", 16'd0);
        step();

        // Saturation: a self-dependent load reissues, stalling two cycles out of three
        for (int i = 0; i < 30; i++) begin
            drv(1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 2'b10, 2'b10, 1'b0);
            exp_stall("sat_pattern", (i % 3) != 0);
            step();
        end
        exp_cnt("sat_count20", 16'd20);
        step();
        // Jump the counter close to the ceiling instead of running 65k stall cycles
        force dut.r_stall_count = 16'hFFF0;
        #1;
        release dut.r_stall_count;
        for (int i = 31; i < 60; i++) begin
            exp_stall("sat_pattern2", (i % 3) != 0);
            step();
        end
        exp_cnt("sat_hold1", 16'hFFFF);
        step();
        step();
        exp_stall("sat_stall_more", 1'b1);
        exp_cnt("sat_hold2", 16'hFFFF);
        step();

        idle();
        step();
        step();

        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL end_stall: got %b, want 0", stall);
        end
        total++;
        if (fwd_hit !== 4'b0000) begin
            bad++;
            $display("FAIL end_fwd_hit: got %b, want 0000", fwd_hit);
        end
        total++;
        if (stall_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL end_cnt: got %h, want ffff", stall_count);
        end

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no check, want %h", e.name, e.val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
